// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared widths, 50 MHz divisor presets and index-width helper
//            for the clk_div_bank divider family.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 26;

    // Divisors are half-period minus one, in 50 MHz clock cycles
    localparam int DIV_1KHZ    = 24_999;
    localparam int DIV_60KHZ   = 415;
    localparam int DIV_FAST    = 5;
    localparam int DIV_VGA_PIX = 0;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank_if
// Brief    : Divisor-load handshake bundle between a host and clk_div_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = clk_div_pkg::CNT_W_DEFAULT
);
    import clk_div_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic             load_valid;
    logic             load_ready;
    logic [CH_W-1:0]  load_ch;
    logic [CNT_W-1:0] load_div;
    logic             load_err;

    modport master (
        output load_valid,
        output load_ch,
        output load_div,
        input  load_ready,
        input  load_err
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_div,
        output load_ready,
        output load_err
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_channel
// Brief    : One divider channel: counter, active/pending divisor, square
//            output and terminal-count tick.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_channel #(
    parameter int CNT_W    = clk_div_pkg::CNT_W_DEFAULT,
    parameter int DIV_INIT = clk_div_pkg::DIV_1KHZ
) (
    input  wire             clk,
    input  wire             rst_N,
    input  wire             en,
    input  wire             load_stb,
    input  wire [CNT_W-1:0] load_div,
    output logic            busy,
    output logic            tick,
    output logic            clkout
);

    localparam logic [CNT_W-1:0] C_DIV_INIT = CNT_W'(DIV_INIT);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] div_act_q,  div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             busy_q,     busy_d;
    logic             tick_q,     tick_d;
    logic             clkout_q,   clkout_d;
    logic             w_term;

    // Compare before increment so an all-ones divisor never wraps the counter
    assign w_term = (cnt_q == div_act_q);

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        busy_d     = busy_q;
        tick_d     = 1'b0;
        clkout_d   = clkout_q;

        if (!en) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
            if (busy_q) begin
                div_act_d = div_pend_q;
                busy_d    = 1'b0;
            end
        end else if (w_term) begin
            cnt_d    = '0;
            clkout_d = ~clkout_q;
            tick_d   = 1'b1;
            if (busy_q) begin
                div_act_d = div_pend_q;
                busy_d    = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A load only arrives while idle, so it lands after this cycle's apply
        if (load_stb) begin
            div_pend_d = load_div;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            cnt_q      <= '0;
            div_act_q  <= C_DIV_INIT;
            div_pend_q <= '0;
            busy_q     <= 1'b0;
            tick_q     <= 1'b0;
            clkout_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            busy_q     <= busy_d;
            tick_q     <= tick_d;
            clkout_q   <= clkout_d;
        end
    end

    assign busy   = busy_q;
    assign tick   = tick_q;
    assign clkout = clkout_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : Bank of NUM_CH programmable tick/square-wave dividers with a
//            valid/ready divisor-load port.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = clk_div_pkg::CNT_W_DEFAULT,
    parameter int DIV_INIT = clk_div_pkg::DIV_1KHZ
) (
    input  wire              clkin,
    input  wire              rst_N,
    input  wire [NUM_CH-1:0] ch_en,
    clk_div_bank_if.slave    ld,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clkout
);
    import clk_div_pkg::*;

    localparam int CH_W  = ch_idx_w(NUM_CH);
    localparam int IDX_N = 1 << CH_W;

    logic [IDX_N-1:0]  w_busy_ext;
    logic              w_in_range;
    logic              w_accept;
    logic [NUM_CH-1:0] w_load_stb;
    logic              load_err_q, load_err_d;

    // Widen busy to the full index space so out-of-range indices read as idle
    assign w_busy_ext    = IDX_N'(busy);
    assign w_in_range    = (32'(ld.load_ch) < NUM_CH);
    assign ld.load_ready = rst_N & (~w_in_range | ~w_busy_ext[ld.load_ch]);
    assign w_accept      = ld.load_valid & ld.load_ready;

    always_comb begin
        load_err_d = w_accept & ~w_in_range;
    end

    always_ff @(posedge clkin) begin
        if (!rst_N) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign ld.load_err = load_err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_load_stb[gi] = w_accept & w_in_range & (32'(ld.load_ch) == gi);

        clk_div_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk      (clkin),
            .rst_N    (rst_N),
            .en       (ch_en[gi]),
            .load_stb (w_load_stb[gi]),
            .load_div (ld.load_div),
            .busy     (busy[gi]),
            .tick     (tick[gi]),
            .clkout   (clkout[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Self-checking bench for clk_div_bank: vector table, directed
//            corner sequences and randomized traffic against an event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NUM_CH   = 5;
    localparam int CNT_W    = CNT_W_DEFAULT;
    localparam int DIV_INIT = DIV_1KHZ;
    localparam int CH_W     = ch_idx_w(NUM_CH);

    logic              clkin = 1'b0;
    logic              rst_N;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clkout;

    clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) ld ();

    clk_div_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clkin  (clkin),
        .rst_N  (rst_N),
        .ch_en  (ch_en),
        .ld     (ld),
        .busy   (busy),
        .tick   (tick),
        .clkout (clkout)
    );

    always #5 clkin = ~clkin;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint tlog [NUM_CH][$];

    // Event-time reference: each running channel knows the cycle of its next tick
    logic [CNT_W-1:0]  m_div  [NUM_CH];
    logic [CNT_W-1:0]  m_pend [NUM_CH];
    longint            m_next [NUM_CH];
    logic [NUM_CH-1:0] m_pv, m_run, m_clk, m_tick;
    logic              m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic m_ready(input logic [CH_W-1:0] ch);
        if (rst_N !== 1'b1) return 1'b0;
        if (int'(ch) >= NUM_CH) return 1'b1;
        return ~m_pv[ch];
    endfunction

    initial begin : model_loop
        logic acc;
        forever begin
            @(posedge clkin);
            cyc++;
            if (rst_N !== 1'b1) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_div[i]  = CNT_W'(DIV_INIT);
                    m_pend[i] = '0;
                    m_next[i] = 0;
                end
                m_pv = '0; m_run = '0; m_clk = '0; m_tick = '0; m_err = 1'b0;
            end else begin
                acc = ld.load_valid && m_ready(ld.load_ch);
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!ch_en[i]) begin
                        m_tick[i] = 1'b0;
                        m_clk[i]  = 1'b0;
                        m_run[i]  = 1'b0;
                        if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 1'b0; end
                    end else begin
                        if (!m_run[i]) begin
                            m_run[i]  = 1'b1;
                            m_next[i] = cyc + longint'(m_div[i]);
                        end
                        if (cyc == m_next[i]) begin
                            m_tick[i] = 1'b1;
                            m_clk[i]  = ~m_clk[i];
                            if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 1'b0; end
                            m_next[i] = cyc + longint'(m_div[i]) + 1;
                        end else begin
                            m_tick[i] = 1'b0;
                        end
                    end
                end
                if (acc && int'(ld.load_ch) < NUM_CH) begin
                    m_pend[ld.load_ch] = ld.load_div;
                    m_pv[ld.load_ch]   = 1'b1;
                end
                m_err = acc && (int'(ld.load_ch) >= NUM_CH);
            end
            @(negedge clkin);
            #2;
            check("tick",       tick,          m_tick);
            check("clkout",     clkout,        m_clk);
            check("busy",       busy,          m_pv);
            check("load_err",   ld.load_err,   m_err);
            check("load_ready", ld.load_ready, m_ready(ld.load_ch));
            for (int i = 0; i < NUM_CH; i++)
                if (tick[i] === 1'b1 && tlog[i].size() < 64) tlog[i].push_back(cyc);
        end
    end

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [CNT_W-1:0]  div;
        logic              exp_ready;
        logic              exp_err;
        logic [NUM_CH-1:0] exp_busy;
    } vec_t;

    function automatic vec_t mk(input int ch, input int dv, input logic r, input logic e, input int b);
        vec_t v;
        v.ch = CH_W'(ch); v.div = CNT_W'(dv); v.exp_ready = r; v.exp_err = e; v.exp_busy = NUM_CH'(b);
        return v;
    endfunction

    vec_t   tbl [9];
    longint e1;
    int     stall;
    int     n;

    initial begin : stim
        tbl[0] = mk(0, 7, 1'b1, 1'b0, 5'b00001);
        tbl[1] = mk(0, 9, 1'b0, 1'b0, 5'b00000);
        tbl[2] = mk(5, 1, 1'b1, 1'b1, 5'b00000);
        tbl[3] = mk(7, 1, 1'b1, 1'b1, 5'b00000);
        tbl[4] = mk(4, 2, 1'b1, 1'b0, 5'b10000);
        tbl[5] = mk(3, 2, 1'b1, 1'b0, 5'b01000);
        tbl[6] = mk(3, 4, 1'b0, 1'b0, 5'b00000);
        tbl[7] = mk(2, 5, 1'b1, 1'b0, 5'b00100);
        tbl[8] = mk(6, 0, 1'b1, 1'b1, 5'b00000);

        rst_N = 1'b0; ch_en = '0;
        ld.load_valid = 1'b0; ld.load_ch = '0; ld.load_div = '0;

        // Reset state
        repeat (3) @(negedge clkin);
        #1;
        check("rst_tick",   tick,          '0);
        check("rst_clkout", clkout,        '0);
        check("rst_busy",   busy,          '0);
        check("rst_err",    ld.load_err,   '0);
        check("rst_ready",  ld.load_ready, '0);
        rst_N = 1'b1;
        #1;
        check("ready_after_release", ld.load_ready, 1'b1);

        // Handshake decode table, all channels disabled
        @(negedge clkin); #1;
        for (int k = 0; k < 9; k++) begin
            ld.load_valid = 1'b1; ld.load_ch = tbl[k].ch; ld.load_div = tbl[k].div;
            #1;
            check($sformatf("tbl%0d_ready", k), ld.load_ready, tbl[k].exp_ready);
            @(negedge clkin); #1;
            check($sformatf("tbl%0d_err", k),  ld.load_err, tbl[k].exp_err);
            check($sformatf("tbl%0d_busy", k), busy,        tbl[k].exp_busy);
        end
        ld.load_valid = 1'b0;

        // ch2: div 5 running, load 3 then 9 back-to-back
        repeat (2) @(negedge clkin); #1;
        tlog[2].delete();
        ch_en = 5'b00100; e1 = cyc + 1;
        repeat (2) @(negedge clkin); #1;
        ld.load_valid = 1'b1; ld.load_ch = 3'd2; ld.load_div = 26'd3;
        @(negedge clkin); #1;
        ld.load_div = 26'd9;
        stall = 0;
        while (stall < 20) begin
            #1;
            if (ld.load_ready === 1'b1) break;
            stall++;
            @(negedge clkin); #1;
        end
        @(negedge clkin); #1;
        ld.load_valid = 1'b0;
        check("ch2_stall_cycles", stall, 3);
        repeat (30) @(negedge clkin); #1;
        check("ch2_tick_count_ok", tlog[2].size() >= 4, 1'b1);
        check("ch2_first_tick", tlog[2][0] - e1, 5);
        check("ch2_half_div3",  tlog[2][1] - tlog[2][0], 4);
        check("ch2_half_div9a", tlog[2][2] - tlog[2][1], 10);
        check("ch2_half_div9b", tlog[2][3] - tlog[2][2], 10);
        ch_en = '0;

        // ch3: div 2 running, load 5 exactly on a terminal count
        @(negedge clkin); #1;
        tlog[3].delete();
        ch_en = 5'b01000; e1 = cyc + 1;
        repeat (5) @(negedge clkin); #1;
        ld.load_valid = 1'b1; ld.load_ch = 3'd3; ld.load_div = 26'd5;
        #1;
        check("ch3_ready_at_tc", ld.load_ready, 1'b1);
        @(negedge clkin); #1;
        ld.load_valid = 1'b0;
        repeat (25) @(negedge clkin); #1;
        check("ch3_tick_count_ok", tlog[3].size() >= 5, 1'b1);
        check("ch3_first_tick", tlog[3][0] - e1, 2);
        check("ch3_half_old_a", tlog[3][1] - tlog[3][0], 3);
        check("ch3_half_old_b", tlog[3][2] - tlog[3][1], 3);
        check("ch3_half_new_a", tlog[3][3] - tlog[3][2], 6);
        check("ch3_half_new_b", tlog[3][4] - tlog[3][3], 6);
        ch_en = '0;

        // Randomized traffic; the event model checks every cycle
        @(negedge clkin); #1;
        ch_en = '1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clkin); #1;
            rst_N = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 49) == 0) ch_en = NUM_CH'($urandom);
            ld.load_valid = ($urandom_range(0, 2) == 0);
            ld.load_ch    = CH_W'($urandom_range(0, 7));
            ld.load_div   = CNT_W'($urandom_range(0, 6));
        end
        @(negedge clkin); #1;
        rst_N = 1'b1; ld.load_valid = 1'b0; ch_en = '0;

        // Reset mid-count with a pending divisor on ch0
        repeat (2) @(negedge clkin); #1;
        ld.load_valid = 1'b1; ld.load_ch = 3'd0; ld.load_div = 26'd7;
        @(negedge clkin); #1;
        ld.load_valid = 1'b0;
        @(negedge clkin); #1;
        ch_en = 5'b00001;
        repeat (2) @(negedge clkin); #1;
        ld.load_valid = 1'b1; ld.load_ch = 3'd0; ld.load_div = 26'd3;
        @(negedge clkin); #1;
        ld.load_valid = 1'b0;
        #1;
        check("ch0_busy_before_rst", busy[0], 1'b1);
        @(negedge clkin); #1;
        rst_N = 1'b0;
        @(negedge clkin); #1;
        check("midrst_tick",   tick,          '0);
        check("midrst_clkout", clkout,        '0);
        check("midrst_busy",   busy,          '0);
        check("midrst_ready",  ld.load_ready, '0);
        for (int i = 0; i < NUM_CH; i++) tlog[i].delete();
        rst_N = 1'b1; ch_en = 5'b00011; e1 = cyc + 1;
        ld.load_valid = 1'b1; ld.load_ch = 3'd1; ld.load_div = 26'd0;
        @(negedge clkin); #1;
        ld.load_valid = 1'b0;
        #1;
        check("ch1_busy_pending", busy[1], 1'b1);
        n = 0;
        while (tlog[0].size() < 2 && n < 60000) begin
            @(negedge clkin); #3;
            n++;
        end
        check("ch0_two_ticks_seen", tlog[0].size() >= 2, 1'b1);
        check("ch0_first_tick",  tlog[0][0] - e1 + 1, 25000);
        check("ch0_half_period", tlog[0][1] - tlog[0][0], 25000);
        check("ch1_first_tick",  tlog[1][0] - e1 + 1, 25000);
        check("ch1_fast_a",      tlog[1][1] - tlog[1][0], 1);
        check("ch1_fast_b",      tlog[1][2] - tlog[1][1], 1);
        check("ch1_busy_cleared", busy[1], 1'b0);
        check("idle_ch_ticks", tlog[2].size() + tlog[3].size() + tlog[4].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
